// File: rtl/riscv_structures.sv
// ---------------------------------------------------------------------------
// riscv_structures
// Shared types for the ALU datapath and its arbiter:
//   alu_op_e      - ALU operation encoding
//   alu_req_t     - packed request payload {in1, in2, op, funct3}
//   F3_*          - compare-select encodings understood by the ALU
//   alu_req_pack  - builds an alu_req_t from its fields
// ---------------------------------------------------------------------------
package riscv_structures;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  localparam logic [2:0] F3_EQ  = 3'd0;
  localparam logic [2:0] F3_NE  = 3'd1;
  localparam logic [2:0] F3_LTU = 3'd4;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    alu_op_e     op;
    logic [2:0]  funct3;
  } alu_req_t;

  function automatic alu_req_t alu_req_pack(
    input logic [31:0] in1,
    input logic [31:0] in2,
    input alu_op_e     op,
    input logic [2:0]  funct3
  );
    alu_req_t r;
    r.in1    = in1;
    r.in2    = in2;
    r.op     = op;
    r.funct3 = funct3;
    return r;
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational ALU slice.
//   in1_i, in2_i : 32-bit operands
//   op_i         : ALU_ADD / ALU_SUB produce a sum / difference (mod 2^32);
//                  every other operation yields 0
//   funct3_i     : compare select (EQ, NE, LTU); other codes yield 0
//   result_o     : arithmetic result
//   cond_o       : compare outcome
// ---------------------------------------------------------------------------
module alu
  import riscv_structures::*;
(
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  input  alu_op_e     op_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o,
  output logic        cond_o
);

  // Arithmetic result selection.
  always_comb begin
    result_o = 32'd0;
    case (op_i)
      ALU_ADD: result_o = in1_i + in2_i;
      ALU_SUB: result_o = in1_i - in2_i;
      default: result_o = 32'd0;
    endcase
  end

  // Compare outcome selection.
  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_EQ:   cond_o = (in1_i == in2_i);
      F3_NE:   cond_o = (in1_i != in2_i);
      F3_LTU:  cond_o = (in1_i < in2_i);
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arb_pick.sv
// ---------------------------------------------------------------------------
// alu_arb_pick
// Combinational winner selection for the ALU arbiter. Searches the valid
// vector starting at ptr_i and wrapping at NUM_REQ-1 -> 0; the first set bit
// wins. With ptr_i tied to 0 this is plain lowest-index-first priority.
//   valid_i : request vector
//   ptr_i   : index searched first
//   en_i    : grant permitted this cycle
//   gnt_o   : one-hot grant (all zero when no grant)
//   idx_o   : index of the winner (0 when no grant)
//   any_o   : a grant was issued
// ---------------------------------------------------------------------------
module alu_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Rotating search for the first valid requester at or after ptr_i.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    logic           found;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (en_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(ptr_i) + k;
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end else begin
          cand = cand;
        end
        cand_idx = IDW'(cand);
        if (!found && valid_i[cand_idx]) begin
          gnt_o[cand_idx] = 1'b1;
          idx_o           = cand_idx;
          found           = 1'b1;
        end else begin
          found = found;
        end
      end
      any_o = found;
    end else begin
      any_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU among NUM_REQ requesters with valid/ready handshakes on both
// sides. A grant is issued only when the single-entry output slot is free
// (empty, or being drained this cycle); the winner's operands go through the
// ALU in the grant cycle and the result is registered one cycle later.
//
// Configuration macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   - rotating priority; pointer moves past each winner
//   undefined - fixed priority, lowest index wins (no pointer register)
//
// Ports
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   req_valid/ready    : per-requester handshake (ready is combinational)
//   req_in1/in2        : per-requester operands
//   req_op/req_funct3  : per-requester operation and compare select
//   rsp_valid/ready    : result handshake
//   rsp_id             : index of requester owning the result
//   rsp_result/cond    : registered ALU result and compare outcome
// ---------------------------------------------------------------------------
module alu_arbiter
  import riscv_structures::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_in1,
  input  logic [NUM_REQ-1:0][31:0]  req_in2,
  input  alu_op_e [NUM_REQ-1:0]     req_op,
  input  logic [NUM_REQ-1:0][2:0]   req_funct3,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [31:0]               rsp_result,
  output logic                      rsp_cond
);

  logic               slot_free_s;
  logic               pick_en_s;
  logic [IDW-1:0]     ptr_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDW-1:0]     win_idx_s;
  logic               any_gnt_s;
  alu_req_t           win_req_s;
  logic [31:0]        alu_result_s;
  logic               alu_cond_s;

  logic               rsp_valid_q,  rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q,     rsp_id_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic               rsp_cond_q,   rsp_cond_d;

  // The slot can take a new result when it is empty or drains this cycle.
  // Gating with rst_n keeps every ready low while reset is held.
  assign slot_free_s = !rsp_valid_q || rsp_ready;
  assign pick_en_s   = slot_free_s && rst_n;

  alu_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_s),
    .en_i    (pick_en_s),
    .gnt_o   (gnt_s),
    .idx_o   (win_idx_s),
    .any_o   (any_gnt_s)
  );

  assign req_ready = gnt_s;

  // Steer the granted requester's payload onto the shared ALU.
  always_comb begin
    win_req_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        win_req_s = alu_req_pack(req_in1[i], req_in2[i], req_op[i], req_funct3[i]);
      end else begin
        win_req_s = win_req_s;
      end
    end
  end

  alu u_alu (
    .in1_i    (win_req_s.in1),
    .in2_i    (win_req_s.in2),
    .op_i     (win_req_s.op),
    .funct3_i (win_req_s.funct3),
    .result_o (alu_result_s),
    .cond_o   (alu_cond_s)
  );

  // Output slot next state: load on grant, clear on drain, else hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_cond_d   = rsp_cond_q;
    if (any_gnt_s) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = win_idx_s;
      rsp_result_d = alu_result_s;
      rsp_cond_d   = alu_cond_s;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end else begin
      rsp_valid_d  = rsp_valid_q;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 32'd0;
      rsp_cond_q   <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_cond_q   <= rsp_cond_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cond   = rsp_cond_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Move the pointer just past the winner, wrapping at NUM_REQ-1.
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt_s) begin
      if (int'(win_idx_s) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx_s + IDW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  // Fixed priority: the search always starts at requester 0.
  assign ptr_s = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed self-checking bench for alu_arbiter (NUM_REQ = 2). Expected
// values are hand-computed; the contention sequence follows the build's
// ALU_ARB_ROUND_ROBIN_EN setting.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import riscv_structures::*;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_in1;
  logic [NUM_REQ-1:0][31:0] req_in2;
  alu_op_e [NUM_REQ-1:0]    req_op;
  logic [NUM_REQ-1:0][2:0]  req_funct3;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [31:0]              rsp_result;
  logic                     rsp_cond;

  int total = 0;
  int bad   = 0;
  bit rr_build;

  alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_op     (req_op),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cond   (rsp_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic idx, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f3);
    req_in1[idx]    = a;
    req_in2[idx]    = b;
    req_op[idx]     = op;
    req_funct3[idx] = f3;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] id, input logic [31:0] res,
                           input logic [31:0] cond);
    check({tag, "_valid"},  {31'd0, rsp_valid}, 32'd1);
    check({tag, "_id"},     {31'd0, rsp_id},    id);
    check({tag, "_result"}, rsp_result,         res);
    check({tag, "_cond"},   {31'd0, rsp_cond},  cond);
  endtask

  initial begin
    logic [31:0] exp_id;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    rr_build = 1'b1;
`else
    rr_build = 1'b0;
`endif
    // Reset state, with requests pending to show ready stays low.
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    set_req(1'b0, ALU_ADD, 32'd0, 32'd0, 3'd0);
    set_req(1'b1, ALU_ADD, 32'd0, 32'd0, 3'd0);
    #2;
    check("rst_valid",  {31'd0, rsp_valid}, 32'd0);
    check("rst_id",     {31'd0, rsp_id},    32'd0);
    check("rst_result", rsp_result,         32'd0);
    check("rst_cond",   {31'd0, rsp_cond},  32'd0);
    check("rst_ready",  {30'd0, req_ready}, 32'd0);
    step();
    step();
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Single op: req0 ADD 5+7.
    set_req(1'b0, ALU_ADD, 32'd5, 32'd7, 3'd0);
    req_valid = 2'b01;
    #1;
    check("single_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_rsp("single", 32'd0, 32'd12, 32'd0);
    step();
    check("single_drain", {31'd0, rsp_valid}, 32'd0);

    // Compare: req1 SUB 3-3 EQ, then LTU 2 < 0xFFFFFFFF back to back.
    set_req(1'b1, ALU_SUB, 32'd3, 32'd3, 3'd0);
    req_valid = 2'b10;
    #1;
    check("cmp_eq_ready", {30'd0, req_ready}, 32'd2);
    step();
    check_rsp("cmp_eq", 32'd1, 32'd0, 32'd1);
    set_req(1'b1, ALU_SUB, 32'd2, 32'hFFFF_FFFF, 3'd4);
    #1;
    check("cmp_ltu_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    check_rsp("cmp_ltu", 32'd1, 32'd3, 32'd1);
    step();
    check("cmp_drain", {31'd0, rsp_valid}, 32'd0);

    // Contention: both valid for 6 cycles.
    set_req(1'b0, ALU_ADD, 32'd10, 32'd0, 3'd0);
    set_req(1'b1, ALU_ADD, 32'd20, 32'd0, 3'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      exp_id = rr_build ? 32'(k % 2) : 32'd0;
      #1;
      check("cont_ready", {30'd0, req_ready}, 32'd1 << exp_id);
      step();
      check("cont_id",     {31'd0, rsp_id}, exp_id);
      check("cont_result", rsp_result,      (exp_id == 32'd0) ? 32'd10 : 32'd20);
    end
    req_valid = 2'b00;
    step();
    check("cont_drain", {31'd0, rsp_valid}, 32'd0);

    // Unsupported op gives 0; NE compare of 0xFF vs 0xF0 is true.
    set_req(1'b0, ALU_AND, 32'h0000_00FF, 32'h0000_00F0, 3'd1);
    req_valid = 2'b01;
    #1;
    check("other_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_rsp("other", 32'd0, 32'd0, 32'd1);
    step();

    // Backpressure: result 12 held for 3 cycles while req1 waits.
    rsp_ready = 1'b0;
    set_req(1'b0, ALU_ADD, 32'd5, 32'd7, 3'd0);
    req_valid = 2'b01;
    #1;
    check("bp_ready0", {30'd0, req_ready}, 32'd1);
    step();
    set_req(1'b1, ALU_SUB, 32'd9, 32'd4, 3'd2);
    req_valid = 2'b10;
    #1;
    check("bp_stall_ready", {30'd0, req_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_rsp("bp_hold", 32'd0, 32'd12, 32'd0);
      check("bp_hold_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    check_rsp("bp_next", 32'd1, 32'd5, 32'd0);
    step();
    check("bp_drain", {31'd0, rsp_valid}, 32'd0);

    // Reset mid-operation with a result held in the slot.
    rsp_ready = 1'b0;
    set_req(1'b0, ALU_ADD, 32'd1, 32'd1, 3'd0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check("mid_loaded", rsp_result, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_result", rsp_result,         32'd0);
    step();
    set_req(1'b0, ALU_ADD, 32'd5, 32'd7, 3'd0);
    set_req(1'b1, ALU_ADD, 32'd20, 32'd0, 3'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("post_rst_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_rsp("post_rst", 32'd0, 32'd12, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
